// File: rtl/mandel_pkg.sv
// Shared types and size defaults for the Mandelbrot pixel scheduler and the pixel-to-complex mapper.
package mandel_pkg;

    localparam int DEPTH_W_DEF = 10;
    localparam int X_SIZE_DEF  = 640;
    localparam int Y_SIZE_DEF  = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
    } pix_tag_t;

    // Width of a counter/pointer over n values; never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mandel_pixel_scheduler_if.sv
// Engine dispatch/completion and result-stream signals of the Mandelbrot pixel scheduler.
interface mandel_pixel_scheduler_if
    import mandel_pkg::*;
#(
    parameter int N_ENG   = 4,
    parameter int X_SIZE  = X_SIZE_DEF,
    parameter int Y_SIZE  = Y_SIZE_DEF,
    parameter int DEPTH_W = DEPTH_W_DEF
);
    localparam int X_W = clog2_min1(X_SIZE);
    localparam int Y_W = clog2_min1(Y_SIZE);

    logic [N_ENG-1:0]         eng_start;
    logic [X_W-1:0]           eng_x;
    logic [Y_W-1:0]           eng_y;
    logic [N_ENG-1:0]         eng_done;
    logic [N_ENG*DEPTH_W-1:0] eng_depth;
    logic                     pix_valid;
    logic                     pix_ready;
    logic [DEPTH_W-1:0]       pix_depth;
    logic                     pix_sof;
    logic                     pix_eol;

    modport master (
        output eng_start, eng_x, eng_y, pix_valid, pix_depth, pix_sof, pix_eol,
        input  eng_done, eng_depth, pix_ready
    );

    modport slave (
        input  eng_start, eng_x, eng_y, pix_valid, pix_depth, pix_sof, pix_eol,
        output eng_done, eng_depth, pix_ready
    );

endinterface

// File: rtl/mandel_result_slot.sv
// One engine's result slot: occupancy state, captured depth, raster tag and overrun detection.
//  state | meaning
//  IDLE  | engine free, slot may be dispatched
//  BUSY  | engine computing, waiting for its done pulse
//  FULL  | depth captured, waiting to be retired downstream
module mandel_result_slot
    import mandel_pkg::*;
#(
    parameter int DEPTH_W = DEPTH_W_DEF
) (
    input  logic               out_stream_aclk,
    input  logic               periph_resetn,
    input  logic               start,
    input  pix_tag_t           tag_in,
    input  logic               done,
    input  logic [DEPTH_W-1:0] depth_in,
    input  logic               retire,
    output slot_state_e        state,
    output logic [DEPTH_W-1:0] depth,
    output pix_tag_t           tag,
    output logic               overrun
);

    slot_state_e state_q, state_d;

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q <= IDLE;
            depth   <= '0;
            tag     <= '0;
        end else begin
            state_q <= state_d;
            if (start)
                tag <= tag_in;
            if (done && (state_q == BUSY))
                depth <= depth_in;
        end
    end

    always_comb begin
        state_d = state_q;
        overrun = 1'b0;
        case (state_q)
            IDLE:    if (start)  state_d = BUSY;
            BUSY:    if (done)   state_d = FULL;
            FULL:    if (retire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done && (state_q != BUSY))
            overrun = 1'b1;
    end

    assign state = state_q;

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Raster-order dispatcher and in-order collector for N_ENG Mandelbrot depth engines.
// Optional MANDEL_PERF_CNT_EN adds frame_cycles/stall_cycles performance outputs.
module mandel_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int N_ENG   = 4,
    parameter int X_SIZE  = X_SIZE_DEF,
    parameter int Y_SIZE  = Y_SIZE_DEF,
    parameter int DEPTH_W = DEPTH_W_DEF
) (
    input  logic                     out_stream_aclk,
    input  logic                     periph_resetn,
    input  logic                     cfg_enable,
    mandel_pixel_scheduler_if.master bus,
    output logic                     err_overrun
`ifdef MANDEL_PERF_CNT_EN
    ,
    output logic [31:0]              frame_cycles,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int X_W = clog2_min1(X_SIZE);
    localparam int Y_W = clog2_min1(Y_SIZE);
    localparam int P_W = clog2_min1(N_ENG);
    localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(N_ENG - 1);

    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [P_W-1:0]     dp_q, rp_q;
    slot_state_e        slot_st    [N_ENG];
    logic [DEPTH_W-1:0] slot_depth [N_ENG];
    pix_tag_t           slot_tag   [N_ENG];
    logic [N_ENG-1:0]   start_vec, retire_vec, overrun_vec;
    logic               frame_start, dispatch, cur_valid, retire_fire;
    pix_tag_t           dp_tag;

    // cfg_enable only gates the first pixel of a frame, so a frame in progress always completes.
    assign frame_start = (x_q == '0) && (y_q == '0);
    assign dispatch    = (slot_st[dp_q] == IDLE) && (cfg_enable || !frame_start);
    assign dp_tag      = '{sof: frame_start, eol: (x_q == X_LAST)};
    assign cur_valid   = (slot_st[rp_q] == FULL);
    assign retire_fire = cur_valid && bus.pix_ready;

    always_comb begin
        start_vec        = '0;
        retire_vec       = '0;
        start_vec[dp_q]  = dispatch;
        retire_vec[rp_q] = retire_fire;
    end

    for (genvar i = 0; i < N_ENG; i++) begin : g_slot
        mandel_result_slot #(.DEPTH_W(DEPTH_W)) u_slot (
            .out_stream_aclk (out_stream_aclk),
            .periph_resetn   (periph_resetn),
            .start           (start_vec[i]),
            .tag_in          (dp_tag),
            .done            (bus.eng_done[i]),
            .depth_in        (bus.eng_depth[i*DEPTH_W +: DEPTH_W]),
            .retire          (retire_vec[i]),
            .state           (slot_st[i]),
            .depth           (slot_depth[i]),
            .tag             (slot_tag[i]),
            .overrun         (overrun_vec[i])
        );
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            x_q           <= '0;
            y_q           <= '0;
            dp_q          <= '0;
            rp_q          <= '0;
            bus.eng_start <= '0;
            bus.eng_x     <= '0;
            bus.eng_y     <= '0;
            err_overrun   <= 1'b0;
        end else begin
            bus.eng_start <= start_vec;
            err_overrun   <= err_overrun | (|overrun_vec);
            if (dispatch) begin
                bus.eng_x <= x_q;
                bus.eng_y <= y_q;
                dp_q      <= (dp_q == P_LAST) ? '0 : dp_q + P_W'(1);
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
            if (retire_fire)
                rp_q <= (rp_q == P_LAST) ? '0 : rp_q + P_W'(1);
        end
    end

    assign bus.pix_valid = cur_valid;
    assign bus.pix_depth = cur_valid ? slot_depth[rp_q] : '0;
    assign bus.pix_sof   = cur_valid & slot_tag[rp_q].sof;
    assign bus.pix_eol   = cur_valid & slot_tag[rp_q].eol;

`ifdef MANDEL_PERF_CNT_EN
    logic [31:0] frame_cnt_q, stall_cnt_q;
    logic        sof_retire;

    assign sof_retire = retire_fire && slot_tag[rp_q].sof;

    // Counters restart on each sof retire; the finished frame's totals are latched at that point.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            frame_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            frame_cycles <= '0;
            stall_cycles <= '0;
        end else if (sof_retire) begin
            frame_cycles <= sat_inc32(frame_cnt_q);
            stall_cycles <= stall_cnt_q;
            frame_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= sat_inc32(frame_cnt_q);
            if (!cur_valid)
                stall_cnt_q <= sat_inc32(stall_cnt_q);
        end
    end
`endif

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Scoreboard bench for mandel_pixel_scheduler: 4 engines on an 8x4 frame with a behavioural engine model.
module tb_mandel_pixel_scheduler;

    localparam int N  = 4;
    localparam int XS = 8;
    localparam int YS = 4;
    localparam int DW = 10;

    typedef struct packed {
        logic [DW-1:0] depth;
        logic          sof;
        logic          eol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_enable = 1'b0;
    logic err_overrun;

    always #5 clk = ~clk;

    mandel_pixel_scheduler_if #(.N_ENG(N), .X_SIZE(XS), .Y_SIZE(YS), .DEPTH_W(DW)) bus ();

    mandel_pixel_scheduler #(.N_ENG(N), .X_SIZE(XS), .Y_SIZE(YS), .DEPTH_W(DW)) dut (
        .out_stream_aclk (clk),
        .periph_resetn   (rst_n),
        .cfg_enable      (cfg_enable),
        .bus             (bus),
        .err_overrun     (err_overrun)
    );

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_err = 0;
    int            ex = 0, ey = 0;
    int            n_starts = 0;
    int            rx_cnt = 0;
    int            rp_model = 0;
    bit            owned [N];
    bit            busy  [N];
    int            cnt   [N];
    logic [DW-1:0] edepth [N];
    logic [N-1:0]  done_v;
    bit            rand_lat = 0;
    bit            hold_ready = 0;
    bit            spur_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Engine model: starts are checked against the bench's own raster walk and pushed to the scoreboard.
    initial begin
        bus.eng_done  = '0;
        bus.eng_depth = '0;
        forever begin
            @(negedge clk);
            done_v = '0;
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    busy[i]  = 0;
                    owned[i] = 0;
                end
                sb.delete();
                ex = 0;
                ey = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (busy[i]) begin
                        cnt[i]--;
                        if (cnt[i] <= 0) begin
                            done_v[i] = 1'b1;
                            busy[i]   = 0;
                            bus.eng_depth[i*DW +: DW] = edepth[i];
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.eng_start[i]) begin
                        chk("start_slot_free", 32'(owned[i]), 0);
                        chk("eng_x", 32'(bus.eng_x), ex);
                        chk("eng_y", 32'(bus.eng_y), ey);
                        owned[i]  = 1;
                        busy[i]   = 1;
                        cnt[i]    = rand_lat ? int'($urandom_range(1, 40)) : 5;
                        edepth[i] = DW'(int'(bus.eng_x) + XS * int'(bus.eng_y));
                        sb.push_back('{depth: DW'(ex + XS * ey), sof: (ex == 0 && ey == 0), eol: (ex == XS - 1)});
                        n_starts++;
                        if (ex == XS - 1) begin
                            ex = 0;
                            ey = (ey == YS - 1) ? 0 : ey + 1;
                        end else begin
                            ex++;
                        end
                    end
                end
                if (spur_req) begin
                    done_v[2] = 1'b1;
                    spur_req  = 0;
                end
            end
            bus.eng_done = done_v;
        end
    end

    // Collector: drives pix_ready and compares each presented result with the scoreboard head.
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.pix_ready = !hold_ready;
            if (!rst_n) begin
                rp_model = 0;
            end else if (bus.pix_valid) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    chk("pix_depth", 32'(bus.pix_depth), 32'(sb[0].depth));
                    chk("pix_sof", 32'(bus.pix_sof), 32'(sb[0].sof));
                    chk("pix_eol", 32'(bus.pix_eol), 32'(sb[0].eol));
                    if (bus.pix_ready) begin
                        void'(sb.pop_front());
                        rx_cnt++;
                        owned[rp_model] = 0;
                        rp_model = (rp_model + 1) % N;
                    end
                end
            end
        end
    end

    task automatic wait_rx(input int target, input string tag);
        int k = 0;
        while (rx_cnt < target && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rx_in_time"}, 32'(rx_cnt >= target), 1);
    endtask

    task automatic stop_and_drain(input string tag);
        int k = 0;
        int s0;
        cfg_enable = 1'b0;
        while (!(sb.size() == 0 && ex == 0 && ey == 0) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_drained_in_time"}, 32'(k < 4000), 1);
        s0 = n_starts;
        repeat (40) @(negedge clk);
        chk({tag, "_no_start_after_stop"}, n_starts, s0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_valid_low"}, 32'(bus.pix_valid), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_eng_start"}, 32'(bus.eng_start), 0);
        chk({tag, "_eng_x"}, 32'(bus.eng_x), 0);
        chk({tag, "_eng_y"}, 32'(bus.eng_y), 0);
        chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
        chk({tag, "_pix_depth"}, 32'(bus.pix_depth), 0);
        chk({tag, "_pix_sof"}, 32'(bus.pix_sof), 0);
        chk({tag, "_pix_eol"}, 32'(bus.pix_eol), 0);
        chk({tag, "_err_overrun"}, 32'(err_overrun), 0);
    endtask

    initial begin
        int r0;
        int k;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("disabled_no_start", n_starts, 0);

        // fixed latency 5, one full frame
        cfg_enable = 1'b1;
        wait_rx(32, "fixed_lat_frame");

        // random latencies, out-of-order completion
        rand_lat = 1;
        wait_rx(64, "random_lat_frame");

        // downstream back-pressure for 20 cycles
        wait_rx(70, "pre_hold");
        hold_ready = 1;
        @(negedge clk);
        r0 = rx_cnt;
        repeat (19) @(negedge clk);
        chk("hold_no_retire", rx_cnt, r0);
        hold_ready = 0;
        wait_rx(96, "post_hold");
        chk("no_overrun_normal", 32'(err_overrun), 0);

        // drop enable at pixel 10 of a frame
        k = 0;
        while ((n_starts % 32) != 10 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_pixel10", 32'(k < 4000), 1);
        stop_and_drain("enable_drop");
        chk("frame_completed", rx_cnt % 32, 0);
        chk("starts_frame_aligned", n_starts % 32, 0);

        // spurious done on idle slot 2
        spur_req = 1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("spur_no_valid", 32'(bus.pix_valid), 0);
            @(negedge clk);
        end
        chk("spur_overrun_set", 32'(err_overrun), 1);

        // re-raise: next frame starts at sof
        r0 = rx_cnt;
        cfg_enable = 1'b1;
        wait_rx(r0 + 32, "reenable_frame");
        chk("overrun_sticky", 32'(err_overrun), 1);

        // asynchronous reset mid-frame
        wait_rx(rx_cnt + 10, "pre_reset");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        chk("reset_sb_cleared", sb.size(), 0);
        rst_n = 1'b1;
        r0 = rx_cnt;
        wait_rx(r0 + 32, "post_reset_frame");
        chk("post_reset_no_overrun", 32'(err_overrun), 0);
        stop_and_drain("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
